// File: rtl/dw_alu_pkg.sv
// Shared definitions for the sequential add/subtract datapath: FSM state
// encoding, operation select encoding and the default slice width.
package dw_alu_pkg;

  localparam int unsigned HALF_W_DEF = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

endpackage

// File: rtl/add16_slice.sv
// Combinational W-bit adder slice with carry-in. It also exposes the carry
// into its MSB so the caller can derive signed overflow.
module add16_slice
  import dw_alu_pkg::*;
#(
  parameter int unsigned W = HALF_W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] full;

  // One-extra-bit add; the carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    full     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    sum      = full[W-1:0];
    cout     = full[W];
    c_msb_in = x[W-1] ^ y[W-1] ^ full[W-1];
  end

endmodule

// File: rtl/dw_addsub_seq.sv
// Two-cycle sequential add/subtract over 2*HALF_W bits using a single
// HALF_W slice adder: low half in LO, high half in HI.
// Optional feature: define DW_ADDSUB_OVF_EN to add the psw_v overflow flag.
module dw_addsub_seq
  import dw_alu_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic                use_c,
  input  logic                flag_we,
  input  logic [2*HALF_W-1:0] a,
  input  logic [2*HALF_W-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [2*HALF_W-1:0] result,
  output logic                psw_c,
  output logic                psw_z,
  output logic                psw_n
`ifdef DW_ADDSUB_OVF_EN
  ,
  output logic                psw_v
`endif
);

  localparam int unsigned W = 2 * HALF_W;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                op_q, op_d;
  // use_c is folded into the latched carry-in at accept time, so psw_c is
  // sampled exactly at the start-accept edge.
  logic                cin_q, cin_d;
  logic                flag_we_q, flag_we_d;
  logic [HALF_W-1:0]   lo_sum_q, lo_sum_d;
  logic                lo_c_q, lo_c_d;
  logic [W-1:0]        result_q, result_d;
  logic                done_q, done_d;
  logic                psw_c_q, psw_c_d;
  logic                psw_z_q, psw_z_d;
  logic                psw_n_q, psw_n_d;
`ifdef DW_ADDSUB_OVF_EN
  logic                psw_v_q, psw_v_d;
`endif

  logic [HALF_W-1:0]   slice_x;
  logic [HALF_W-1:0]   slice_y_raw;
  logic [HALF_W-1:0]   slice_y;
  logic                slice_ci;
  logic [HALF_W-1:0]   slice_sum;
  logic                slice_co;
`ifdef DW_ADDSUB_OVF_EN
  logic                slice_cmsb;
`else
  logic                slice_cmsb_unused;
`endif

  // Steer the operand halves and carry-in into the shared slice by state.
  always_comb begin
    if (state_q == HI) begin
      slice_x     = a_q[W-1:HALF_W];
      slice_y_raw = b_q[W-1:HALF_W];
      slice_ci    = lo_c_q;
    end else begin
      slice_x     = a_q[HALF_W-1:0];
      slice_y_raw = b_q[HALF_W-1:0];
      slice_ci    = cin_q;
    end
    slice_y = (op_q == OP_SUB) ? ~slice_y_raw : slice_y_raw;
  end

  add16_slice #(
    .W (HALF_W)
  ) u_slice (
    .x        (slice_x),
    .y        (slice_y),
    .cin      (slice_ci),
    .sum      (slice_sum),
    .cout     (slice_co),
`ifdef DW_ADDSUB_OVF_EN
    .c_msb_in (slice_cmsb)
`else
    .c_msb_in (slice_cmsb_unused)
`endif
  );

  // Next-state and datapath update; everything holds unless its state acts.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cin_d     = cin_q;
    flag_we_d = flag_we_q;
    lo_sum_d  = lo_sum_q;
    lo_c_d    = lo_c_q;
    result_d  = result_q;
    done_d    = 1'b0;
    psw_c_d   = psw_c_q;
    psw_z_d   = psw_z_q;
    psw_n_d   = psw_n_q;
`ifdef DW_ADDSUB_OVF_EN
    psw_v_d   = psw_v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LO;
          a_d       = a;
          b_d       = b;
          op_d      = op;
          cin_d     = use_c ? psw_c_q : op;
          flag_we_d = flag_we;
        end
      end
      LO: begin
        state_d  = HI;
        lo_sum_d = slice_sum;
        lo_c_d   = slice_co;
      end
      HI: begin
        state_d  = IDLE;
        result_d = {slice_sum, lo_sum_q};
        done_d   = 1'b1;
        if (flag_we_q) begin
          psw_c_d = slice_co;
          psw_z_d = ({slice_sum, lo_sum_q} == '0);
          psw_n_d = slice_sum[HALF_W-1];
`ifdef DW_ADDSUB_OVF_EN
          psw_v_d = slice_cmsb ^ slice_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand, partial-sum, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      cin_q     <= 1'b0;
      flag_we_q <= 1'b0;
      lo_sum_q  <= '0;
      lo_c_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      psw_c_q   <= 1'b0;
      psw_z_q   <= 1'b0;
      psw_n_q   <= 1'b0;
`ifdef DW_ADDSUB_OVF_EN
      psw_v_q   <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cin_q     <= cin_d;
      flag_we_q <= flag_we_d;
      lo_sum_q  <= lo_sum_d;
      lo_c_q    <= lo_c_d;
      result_q  <= result_d;
      done_q    <= done_d;
      psw_c_q   <= psw_c_d;
      psw_z_q   <= psw_z_d;
      psw_n_q   <= psw_n_d;
`ifdef DW_ADDSUB_OVF_EN
      psw_v_q   <= psw_v_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign psw_c  = psw_c_q;
  assign psw_z  = psw_z_q;
  assign psw_n  = psw_n_q;
`ifdef DW_ADDSUB_OVF_EN
  assign psw_v  = psw_v_q;
`endif

endmodule

// File: doc/dw_addsub_seq.md
DW_ADDSUB_SEQ -- requirements
Module: dw_addsub_seq

Interface
REQ-001 The block SHALL have parameter HALF_W, default 16, meaning the width of one adder slice; the operand width SHALL be 2*HALF_W.
REQ-002 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1: reset, asynchronous and active-high.
REQ-004 Port start  input  1: request pulse; SHALL be sampled only in IDLE.
REQ-005 Port op  input  1: operation select; 0 = add, 1 = subtract (A - B).
REQ-006 Port use_c  input  1: 1 = carry-in taken from psw_c (ADC/SBC); 0 = carry-in fixed by op.
REQ-007 Port flag_we  input  1: 1 = update the PSW flags when the operation completes.
REQ-008 Port a  input  32: operand A.
REQ-009 Port b  input  32: operand B.
REQ-010 Port busy  output  1: high while an operation is in flight (states LO and HI).
REQ-011 Port done  output  1: one-cycle completion pulse.
REQ-012 Port result  output  32: registered result.
REQ-013 Ports psw_c, psw_z, psw_n  output  1 each: registered carry, zero and negative flags.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LO and HI.
REQ-015 IDLE with start=1 SHALL latch a, b, op, use_c and flag_we and go to LO; IDLE with start=0 SHALL stay in IDLE.
REQ-016 LO SHALL compute bits [15:0] through the slice adder, register the low sum and slice carry-out, and go to HI.
REQ-017 HI SHALL compute bits [31:16] with carry-in = registered low carry, write result, conditionally update flags, assert done for the next cycle, and go to IDLE.
REQ-018 The operation SHALL be result = A + (op ? ~B : B) + cin, with cin = use_c ? psw_c : op.
REQ-019 cin SHALL be taken from psw_c as it stands at the start-accept edge.
REQ-020 Latency SHALL be: start accepted at edge N; result and done valid in the cycle after edge N+2.
REQ-021 busy SHALL be high in the cycles after edges N and N+1.
REQ-022 If flag_we was latched as 1: psw_c SHALL equal the carry out of bit 31 (on subtract, 1 = no borrow), psw_z SHALL be (result == 0) over all 32 bits, and psw_n SHALL be result[31].
REQ-023 If flag_we was latched as 0, the flags SHALL hold their values.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 start during the done cycle SHALL be accepted, giving back-to-back throughput of one operation per 3 cycles.
REQ-026 result SHALL hold between completions, and any input change while busy SHALL have no effect.
REQ-027 Wrap-around SHALL be modulo 2^32, with no saturation.

Reset
REQ-028 rst SHALL force: state IDLE; busy, done, result, psw_c, psw_z, psw_n and psw_v to 0; latched operands to 0.
REQ-029 rst asserted mid-operation SHALL abort it: no done pulse and no flag update.

Configuration
REQ-030 Macro DW_ADDSUB_OVF_EN defined SHALL add output port psw_v (input-side B is the already-inverted operand on subtract).
- psw_v SHALL be updated with flag_we as signed overflow = carry into bit 31 XOR carry out of bit 31.
REQ-031 Macro DW_ADDSUB_OVF_EN undefined SHALL remove port psw_v and all overflow logic, leaving no other change.

Structure
REQ-032 The shared package dw_alu_pkg SHALL hold:
- the state enum (IDLE, LO, HI);
- op encoding constants OP_ADD = 0 and OP_SUB = 1;
- the HALF_W default.
REQ-033 Sub-module add16_slice SHALL be combinational with inputs x, y, cin and outputs sum, cout, c_msb_in (the carry into its MSB, for overflow).
REQ-034 dw_addsub_seq SHALL instantiate add16_slice once and reuse it in both LO and HI.

Verification
REQ-035 Scenario: a=0x0000FFFF, b=0x00000001, op=0, use_c=0, flag_we=1 -> result=0x00010000, C=0, Z=0, N=0, with done 3 cycles after start.
REQ-036 Scenario: a=0x00000004, b=0x00000004, op=1, flag_we=1 -> result=0, Z=1, C=1 (no borrow).
REQ-037 Scenario: a=0x00000000, b=0x00000001, op=1 -> result=0xFFFFFFFF, N=1, C=0; then use_c=1, op=1, a=5, b=2 -> result=2 (borrow propagated).
REQ-038 Scenario: with DW_ADDSUB_OVF_EN defined, a=0x7FFFFFFF, b=1, op=0 -> result=0x80000000, V=1, N=1; and a=0xFFFFFFFF, b=0x00000002, op=1 -> result=0xFFFFFFFD, V=0.
REQ-039 Scenario: start re-pulsed while busy, and new operands applied mid-op -> exactly one done pulse, with the result from the original operands.
REQ-040 Scenario: rst pulsed in HI -> no done pulse and flags remain 0; then start accepted normally in the cycle after rst deasserts.
